// File: rtl/tri_raster.sv
// Triangle rasterizer: scans the vertex bounding box row-major and streams the pixels that pass the three-edge sign test.
// Optional `RASTER_STATS_EN` adds a per-triangle pixel handshake counter on port pix_count.
module tri_raster #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tri_valid,
    output logic         tri_ready,
    input  logic [W-1:0] p1x,
    input  logic [W-1:0] p1y,
    input  logic [W-1:0] p2x,
    input  logic [W-1:0] p2y,
    input  logic [W-1:0] p3x,
    input  logic [W-1:0] p3y,
    output logic         pix_valid,
    input  logic         pix_ready,
    output logic [W-1:0] pix_x,
    output logic [W-1:0] pix_y,
    output logic         done
`ifdef RASTER_STATS_EN
    ,
    output logic [23:0]  pix_count
`endif
);

    localparam int PW = 2*W + 2;
    localparam int EW = 2*W + 3;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SCAN, S_DONE} state_t;

    state_t       r_state, w_next;
    logic [W-1:0] r_p1x, r_p1y, r_p2x, r_p2y, r_p3x, r_p3y;
    logic [W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
    logic [W-1:0] r_cx, r_cy;
    logic [W-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
    logic         w_s1, w_s2, w_s3;
    logic         w_inside, w_advance, w_last;

    function automatic logic [W-1:0] min3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [W-1:0] max3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Returns 1 when E >= 0 for edge A->B at point Q; full precision, no truncation.
    function automatic logic edge_sign(input logic [W-1:0] ax, input logic [W-1:0] ay,
                                       input logic [W-1:0] bx, input logic [W-1:0] by,
                                       input logic [W-1:0] qx, input logic [W-1:0] qy);
        logic signed [W:0]    dqx, day, dax, dqy;
        logic signed [PW-1:0] m0, m1;
        logic signed [EW-1:0] e;
        dqx = $signed({1'b0, qx}) - $signed({1'b0, bx});
        day = $signed({1'b0, ay}) - $signed({1'b0, by});
        dax = $signed({1'b0, ax}) - $signed({1'b0, bx});
        dqy = $signed({1'b0, qy}) - $signed({1'b0, by});
        m0  = PW'(dqx) * PW'(day);
        m1  = PW'(dax) * PW'(dqy);
        e   = EW'(m0) - EW'(m1);
        return ~e[EW-1];
    endfunction

    always_comb begin
        w_xmin = min3(r_p1x, r_p2x, r_p3x);
        w_xmax = max3(r_p1x, r_p2x, r_p3x);
        w_ymin = min3(r_p1y, r_p2y, r_p3y);
        w_ymax = max3(r_p1y, r_p2y, r_p3y);
    end

    always_comb begin
        w_s1      = edge_sign(r_p1x, r_p1y, r_p2x, r_p2y, r_cx, r_cy);
        w_s2      = edge_sign(r_p2x, r_p2y, r_p3x, r_p3y, r_cx, r_cy);
        w_s3      = edge_sign(r_p3x, r_p3y, r_p1x, r_p1y, r_cx, r_cy);
        w_inside  = (w_s1 == w_s2) && (w_s2 == w_s3);
        w_advance = !w_inside || pix_ready;
        w_last    = (r_cx == r_xmax) && (r_cy == r_ymax);
    end

    assign tri_ready = (r_state == S_IDLE);
    assign pix_valid = (r_state == S_SCAN) && w_inside;
    assign done      = (r_state == S_DONE);
    assign pix_x     = r_cx;
    assign pix_y     = r_cy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (tri_valid) w_next = S_SETUP;
            S_SETUP: w_next = S_SCAN;
            S_SCAN:  if (w_advance && w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1x  <= '0; r_p1y <= '0;
            r_p2x  <= '0; r_p2y <= '0;
            r_p3x  <= '0; r_p3y <= '0;
            r_xmin <= '0; r_xmax <= '0;
            r_ymin <= '0; r_ymax <= '0;
            r_cx   <= '0; r_cy  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (tri_valid) begin
                        r_p1x <= p1x; r_p1y <= p1y;
                        r_p2x <= p2x; r_p2y <= p2y;
                        r_p3x <= p3x; r_p3y <= p3y;
                    end
                end
                S_SETUP: begin
                    r_xmin <= w_xmin; r_xmax <= w_xmax;
                    r_ymin <= w_ymin; r_ymax <= w_ymax;
                    r_cx   <= w_xmin; r_cy   <= w_ymin;
                end
                S_SCAN: begin
                    // The last candidate leaves the counters untouched so they never wrap past 4095.
                    if (w_advance && !w_last) begin
                        if (r_cx == r_xmax) begin
                            r_cx <= r_xmin;
                            r_cy <= r_cy + 1'b1;
                        end else begin
                            r_cx <= r_cx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RASTER_STATS_EN
    logic [23:0] r_count;
    assign pix_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_count <= '0;
        else if (tri_ready && tri_valid)           r_count <= '0;
        else if (pix_valid && pix_ready)           r_count <= r_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_tri_raster.sv
// Directed bench for tri_raster: hand-derived pixel lists, latency, stall, reset-abort and input-ignore cases.
module tb_tri_raster;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tri_valid = 1'b0;
    logic        tri_ready;
    logic [11:0] p1x = '0, p1y = '0, p2x = '0, p2y = '0, p3x = '0, p3y = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [11:0] pix_x, pix_y;
    logic        done;
`ifdef RASTER_STATS_EN
    logic [23:0] pix_count;
`endif

    tri_raster #(.W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tri_valid (tri_valid),
        .tri_ready (tri_ready),
        .p1x       (p1x),
        .p1y       (p1y),
        .p2x       (p2x),
        .p2y       (p2y),
        .p3x       (p3x),
        .p3y       (p3y),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .done      (done)
`ifdef RASTER_STATS_EN
        ,
        .pix_count (pix_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [23:0] got_q[$];
    logic [23:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Expected lists, one helper per test triangle.
    task automatic exp_t1();
        exp_q.delete();
        for (int y = 1; y <= 4; y++)
            for (int x = y - 1; x <= 7 - y; x++) exp_q.push_back({12'(x), 12'(y)});
    endtask

    task automatic exp_big();
        exp_q.delete();
        for (int y = 4090; y <= 4095; y++)
            for (int x = 4090; x <= 8185 - y; x++) exp_q.push_back({12'(x), 12'(y)});
    endtask

    task automatic exp_diag();
        exp_q.delete();
        for (int i = 0; i <= 4; i++) exp_q.push_back({12'(i), 12'(i)});
    endtask

    task automatic run(input string name,
                       input logic [11:0] ax, input logic [11:0] ay,
                       input logic [11:0] bx, input logic [11:0] by,
                       input logic [11:0] cx, input logic [11:0] cy,
                       input int exp_done, input int stall_k, input int abort_k, input bit jam);
        int done_k, first_k, hold, busy_bad;
        got_q.delete();
        done_k = -1; first_k = -1; hold = 0; busy_bad = 0;
        @(negedge clk);
        check_eq({name, "_idle_ready"}, 32'(tri_ready), 32'd1);
        p1x = ax; p1y = ay; p2x = bx; p2y = by; p3x = cx; p3y = cy;
        tri_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            pix_ready = !(stall_k > 0 && k >= stall_k && k < stall_k + 5);
            if (jam) begin
                p1x = 12'($urandom); p1y = 12'($urandom);
                p2x = 12'($urandom); p2y = 12'($urandom);
                p3x = 12'($urandom); p3y = 12'($urandom);
            end else begin
                tri_valid = 1'b0;
            end
            if (k == abort_k) begin
                check_eq({name, "_pre_abort_valid"}, 32'(pix_valid), 32'd1);
                rst_n = 1'b0;
                #1;
                check_eq({name, "_abort_pix_valid"}, 32'(pix_valid), 32'd0);
                check_eq({name, "_abort_tri_ready"}, 32'(tri_ready), 32'd1);
`ifdef RASTER_STATS_EN
                check_eq({name, "_abort_count"}, 32'(pix_count), 32'd0);
`endif
                tri_valid = 1'b0;
                pix_ready = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (k == 1) check_eq({name, "_setup_busy"}, 32'(tri_ready), 32'd0);
            if (!done && tri_ready) busy_bad++;
            if (pix_valid && first_k < 0) first_k = k;
            if (pix_valid && exp_q.size() > 0 && {pix_x, pix_y} == exp_q[0]) hold++;
            if (pix_valid && pix_ready) got_q.push_back({pix_x, pix_y});
            if (done) begin
                done_k = k;
                tri_valid = 1'b0;
`ifdef RASTER_STATS_EN
                check_eq({name, "_pix_count"}, 32'(pix_count), 32'(exp_q.size()));
`endif
                break;
            end
        end
        pix_ready = 1'b1;
        tri_valid = 1'b0;
        check_eq({name, "_done_cycle"}, 32'(done_k), 32'(exp_done));
        check_eq({name, "_first_pix_cycle"}, 32'(first_k), 32'd2);
        check_eq({name, "_first_hold"}, 32'(hold), (stall_k > 0) ? 32'd6 : 32'd1);
        check_eq({name, "_busy_during_scan"}, 32'(busy_bad), 32'd0);
        check_eq({name, "_npix"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s_pix%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        @(negedge clk);
        check_eq({name, "_done_pulse_end"}, 32'(done), 32'd0);
        check_eq({name, "_back_idle"}, 32'(tri_ready), 32'd1);
`ifdef RASTER_STATS_EN
        check_eq({name, "_count_hold"}, 32'(pix_count), 32'(exp_q.size()));
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_tri_ready", 32'(tri_ready), 32'd1);
        check_eq("rst_pix_valid", 32'(pix_valid), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_pix_xy", 32'({pix_x, pix_y}), 32'd0);
`ifdef RASTER_STATS_EN
        check_eq("rst_count", 32'(pix_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        exp_t1();
        run("t1", 12'd0, 12'd1, 12'd6, 12'd1, 12'd3, 12'd4, 30, 0, 0, 1'b0);
        exp_t1();
        run("t1stall", 12'd0, 12'd1, 12'd6, 12'd1, 12'd3, 12'd4, 35, 2, 0, 1'b0);
        exp_big();
        run("big", 12'd4090, 12'd4090, 12'd4095, 12'd4090, 12'd4090, 12'd4095, 38, 0, 0, 1'b0);
        exp_q.delete();
        exp_q.push_back({12'd5, 12'd5});
        run("point", 12'd5, 12'd5, 12'd5, 12'd5, 12'd5, 12'd5, 3, 0, 0, 1'b0);
        exp_diag();
        run("diag", 12'd0, 12'd0, 12'd2, 12'd2, 12'd4, 12'd4, 27, 0, 0, 1'b0);
        exp_t1();
        run("abort", 12'd0, 12'd1, 12'd6, 12'd1, 12'd3, 12'd4, 30, 0, 5, 1'b0);
        exp_diag();
        run("diag_after_rst", 12'd0, 12'd0, 12'd2, 12'd2, 12'd4, 12'd4, 27, 0, 0, 1'b0);
        exp_t1();
        run("jam", 12'd0, 12'd1, 12'd6, 12'd1, 12'd3, 12'd4, 30, 0, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
